// File: rtl/simon_kexp_multi.sv
// Run-time configurable Simon key expander covering all ten block/key sizes.
// Generates one round key per clock into local storage, then serves them through a registered read port.
module simon_kexp_multi #(
    parameter int MAX_ROUNDS     = 72,
    parameter int MAX_WORD_WIDTH = 64,
    parameter int KEY_WIDTH      = 256,
    parameter int ADDR_WIDTH     = 7
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic [3:0]                cfg,
    input  logic [KEY_WIDTH-1:0]      key,
    input  logic                      k_valid,
    output logic                      k_ready,
    input  logic                      abort,
    output logic                      exp_valid,
    output logic [6:0]                n_rounds,
    output logic                      cfg_err,
    input  logic                      rk_rd,
    input  logic [ADDR_WIDTH-1:0]     rk_addr,
    output logic [MAX_WORD_WIDTH-1:0] rk_data,
    output logic                      rk_data_valid
);
    typedef logic [MAX_WORD_WIDTH-1:0] word_t;

    typedef struct packed {
        logic       ok;
        logic [6:0] n;
        logic [2:0] m;
        logic [6:0] t;
        logic [2:0] zs;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

    // Literal MSB is z[0], so z[j] lives at bit 61-j.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic cfg_t decode(input logic [3:0] c);
        cfg_t d;
        d    = '0;
        d.ok = 1'b1;
        case (c)
            4'd0:    begin d.n = 7'd16; d.m = 3'd4; d.t = 7'd32; d.zs = 3'd0; end
            4'd1:    begin d.n = 7'd24; d.m = 3'd3; d.t = 7'd36; d.zs = 3'd0; end
            4'd2:    begin d.n = 7'd24; d.m = 3'd4; d.t = 7'd36; d.zs = 3'd1; end
            4'd3:    begin d.n = 7'd32; d.m = 3'd3; d.t = 7'd42; d.zs = 3'd2; end
            4'd4:    begin d.n = 7'd32; d.m = 3'd4; d.t = 7'd44; d.zs = 3'd3; end
            4'd5:    begin d.n = 7'd48; d.m = 3'd2; d.t = 7'd52; d.zs = 3'd2; end
            4'd6:    begin d.n = 7'd48; d.m = 3'd3; d.t = 7'd54; d.zs = 3'd3; end
            4'd7:    begin d.n = 7'd64; d.m = 3'd2; d.t = 7'd68; d.zs = 3'd2; end
            4'd8:    begin d.n = 7'd64; d.m = 3'd3; d.t = 7'd69; d.zs = 3'd3; end
            4'd9:    begin d.n = 7'd64; d.m = 3'd4; d.t = 7'd72; d.zs = 3'd4; end
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction

    function automatic word_t wmask(input logic [6:0] n);
        word_t ones;
        ones = '1;
        return ones >> (MAX_WORD_WIDTH - int'(n));
    endfunction

    function automatic word_t ror(input word_t x, input int r, input logic [6:0] n);
        return ((x >> r) | (x << (int'(n) - r))) & wmask(n);
    endfunction

    function automatic word_t key_word(input logic [KEY_WIDTH-1:0] k, input int j, input logic [6:0] n);
        logic [KEY_WIDTH-1:0] s;
        s = k >> (j * int'(n));
        return s[MAX_WORD_WIDTH-1:0] & wmask(n);
    endfunction

    function automatic logic z_bit(input logic [2:0] sel, input logic [5:0] idx);
        logic [61:0] z;
        case (sel)
            3'd0:    z = Z0;
            3'd1:    z = Z1;
            3'd2:    z = Z2;
            3'd3:    z = Z3;
            default: z = Z4;
        endcase
        return z[6'd61 - idx];
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  cur_cfg;
    cfg_t        in_d, cur_d;
    logic [6:0]  idx;
    logic [5:0]  zi;
    logic [1:0]  back;
    word_t       win [4];
    word_t       mem [MAX_ROUNDS];
    word_t       tmp, k_new;
    logic        offer, accept, bad, wr_en, rd_hit;

    assign in_d   = decode(cfg);
    assign cur_d  = decode(cur_cfg);
    assign offer  = k_valid && k_ready && !abort;
    assign accept = offer && in_d.ok;
    assign bad    = offer && !in_d.ok;
    assign wr_en  = (state == EXP) && !abort;
    assign rd_hit = rk_rd && (state == DONE);
    assign back   = 2'(cur_d.m - 3'd1);

    // State register
    always_ff @(posedge ck) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXP;
            EXP: begin
                if (abort)                         state_nxt = IDLE;
                else if (idx == cur_d.t - 7'd1)    state_nxt = DONE;
            end
            DONE: begin
                if (abort)       state_nxt = IDLE;
                else if (accept) state_nxt = EXP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        k_ready   = (state != EXP);
        exp_valid = (state == DONE);
    end

    // win[0] holds k[i-1], win[1] k[i-2], and so on; k[i-m] is win[m-1].
    always_comb begin
        tmp = ror(win[0], 3, cur_d.n);
        if (cur_d.m == 3'd4) tmp = tmp ^ win[2];
        tmp   = tmp ^ ror(tmp, 1, cur_d.n);
        k_new = (~win[back] ^ tmp ^ {{(MAX_WORD_WIDTH-1){1'b0}}, z_bit(cur_d.zs, zi)}
                 ^ word_t'(2'b11)) & wmask(cur_d.n);
    end

    // Round-key storage and recurrence window are deliberately left uninitialised by reset.
    always_ff @(posedge ck) begin
        if (!rst) begin
            if (accept) begin
                for (int j = 0; j < 4; j++) begin
                    if (j < int'(in_d.m)) mem[j] <= key_word(key, j, in_d.n);
                    win[j] <= (j < int'(in_d.m)) ? key_word(key, int'(in_d.m) - 1 - j, in_d.n) : '0;
                end
            end else if (wr_en) begin
                mem[idx] <= k_new;
                win[0]   <= k_new;
                win[1]   <= win[0];
                win[2]   <= win[1];
                win[3]   <= win[2];
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            cur_cfg       <= '0;
            idx           <= '0;
            zi            <= '0;
            n_rounds      <= '0;
            cfg_err       <= 1'b0;
            rk_data       <= '0;
            rk_data_valid <= 1'b0;
        end else begin
            cfg_err <= bad;
            if (accept) begin
                cur_cfg  <= cfg;
                idx      <= {4'b0, in_d.m};
                zi       <= '0;
                n_rounds <= in_d.t;
            end else if (wr_en) begin
                idx <= idx + 7'd1;
                zi  <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
            end
            // Reads see the schedule as it stood before a same-cycle re-accept.
            rk_data_valid <= rd_hit;
            if (rd_hit) begin
                if (int'(rk_addr) < int'(cur_d.t)) rk_data <= mem[rk_addr];
                else                               rk_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_simon_kexp_multi.sv
// Directed bench for simon_kexp_multi: fixed vectors plus an independent bit-level key schedule model.
module tb_simon_kexp_multi;
    logic         ck = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   cfg = '0;
    logic [255:0] key = '0;
    logic         k_valid = 1'b0;
    logic         k_ready;
    logic         abort = 1'b0;
    logic         exp_valid;
    logic [6:0]   n_rounds;
    logic         cfg_err;
    logic         rk_rd = 1'b0;
    logic [6:0]   rk_addr = '0;
    logic [63:0]  rk_data;
    logic         rk_data_valid;

    int tests = 0;
    int fails = 0;

    int    nt [10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
    int    mt [10] = '{4, 3, 4, 3, 4, 2, 3, 2, 3, 4};
    int    tt [10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
    int    zt [10] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 4};
    string zs [5];

    logic [63:0] exp_k [72];
    logic [63:0] got   [72];
    logic        gotv  [72];

    simon_kexp_multi dut (
        .ck(ck), .rst(rst), .cfg(cfg), .key(key), .k_valid(k_valid), .k_ready(k_ready),
        .abort(abort), .exp_valid(exp_valid), .n_rounds(n_rounds), .cfg_err(cfg_err),
        .rk_rd(rk_rd), .rk_addr(rk_addr), .rk_data(rk_data), .rk_data_valid(rk_data_valid)
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [63:0] rorb(input logic [63:0] x, input int r, input int n);
        logic [63:0] y;
        y = '0;
        for (int b = 0; b < n; b++) y[b] = x[(b + r) % n];
        return y;
    endfunction

    task automatic gen_model(input int c, input logic [255:0] k);
        int n, m, t;
        logic [63:0] msk, cst, tmp, zb;
        logic [255:0] s;
        n   = nt[c]; m = mt[c]; t = tt[c];
        msk = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
        cst = ((64'd1 << n) - 64'd4) & msk;
        for (int j = 0; j < m; j++) begin
            s = k >> (j * n);
            exp_k[j] = s[63:0] & msk;
        end
        for (int i = m; i < t; i++) begin
            tmp = rorb(exp_k[i-1], 3, n);
            if (m == 4) tmp = tmp ^ exp_k[i-3];
            tmp = tmp ^ rorb(tmp, 1, n);
            zb  = (zs[zt[c]].getc((i - m) % 62) == "1") ? 64'd1 : 64'd0;
            exp_k[i] = cst ^ exp_k[i-m] ^ tmp ^ zb;
        end
    endtask

    task automatic accept(input int c, input logic [255:0] k);
        cfg = 4'(c); key = k; k_valid = 1'b1;
        step();
        k_valid = 1'b0;
    endtask

    // Counts cycles with k_ready low; flags any exp_valid seen meanwhile.
    task automatic wait_exp(output int cyc, output logic early);
        cyc = 0; early = 1'b0;
        while (!k_ready && cyc < 300) begin
            if (exp_valid) early = 1'b1;
            cyc++;
            step();
        end
    endtask

    task automatic read_one(input int a);
        rk_addr = 7'(a); rk_rd = 1'b1;
        step();
        rk_rd = 1'b0;
    endtask

    // Back-to-back reads of addresses 0..t-1, one per cycle.
    task automatic read_block(input int t);
        rk_addr = '0; rk_rd = 1'b1;
        for (int a = 0; a < t; a++) begin
            step();
            got[a] = rk_data; gotv[a] = rk_data_valid;
            if (a + 1 < t) rk_addr = 7'(a + 1);
            else           rk_rd = 1'b0;
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests++;
        if (k_ready !== 1'b1 || exp_valid !== 1'b0 || cfg_err !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: k_ready=%b exp_valid=%b cfg_err=%b want 1 0 0", k_ready, exp_valid, cfg_err);
        end
        tests++;
        if (rk_data !== 64'd0 || rk_data_valid !== 1'b0 || n_rounds !== 7'd0) begin
            fails++; $display("FAIL reset_rd: rk_data=%h valid=%b n_rounds=%0d want 0 0 0", rk_data, rk_data_valid, n_rounds);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_cfg7();
        int cyc; logic early;
        accept(7, '0);
        wait_exp(cyc, early);
        tests++;
        if (cyc !== 66 || early !== 1'b0 || exp_valid !== 1'b1) begin
            fails++; $display("FAIL cfg7_latency: busy=%0d early=%b exp_valid=%b want 66 0 1", cyc, early, exp_valid);
        end
        tests++;
        if (n_rounds !== 7'd68) begin
            fails++; $display("FAIL cfg7_nrounds: got %0d want 68", n_rounds);
        end
        read_one(2);
        tests++;
        if (rk_data !== 64'hFFFF_FFFF_FFFF_FFFD || rk_data_valid !== 1'b1) begin
            fails++; $display("FAIL cfg7_k2: got %h v=%b want fffffffffffffffd v=1", rk_data, rk_data_valid);
        end
        read_one(0);
        tests++;
        if (rk_data !== 64'd0 || rk_data_valid !== 1'b1) begin
            fails++; $display("FAIL cfg7_k0: got %h v=%b want 0 v=1", rk_data, rk_data_valid);
        end
        read_one(1);
        tests++;
        if (rk_data !== 64'd0 || rk_data_valid !== 1'b1) begin
            fails++; $display("FAIL cfg7_k1: got %h v=%b want 0 v=1", rk_data, rk_data_valid);
        end
        step();
        tests++;
        if (rk_data_valid !== 1'b0) begin
            fails++; $display("FAIL cfg7_noread: rk_data_valid=%b want 0", rk_data_valid);
        end
    endtask

    task automatic test_cfg0();
        int cyc; logic early;
        accept(0, '0);
        tests++;
        if (exp_valid !== 1'b0 || k_ready !== 1'b0) begin
            fails++; $display("FAIL cfg0_reaccept: exp_valid=%b k_ready=%b want 0 0", exp_valid, k_ready);
        end
        wait_exp(cyc, early);
        tests++;
        if (cyc !== 28 || early !== 1'b0 || exp_valid !== 1'b1) begin
            fails++; $display("FAIL cfg0_latency: busy=%0d early=%b exp_valid=%b want 28 0 1", cyc, early, exp_valid);
        end
        read_one(4);
        tests++;
        if (rk_data !== 64'h0000_0000_0000_FFFD || rk_data_valid !== 1'b1) begin
            fails++; $display("FAIL cfg0_k4: got %h v=%b want 000000000000fffd v=1", rk_data, rk_data_valid);
        end
        read_one(32);
        tests++;
        if (rk_data !== 64'd0 || rk_data_valid !== 1'b1) begin
            fails++; $display("FAIL cfg0_oob: got %h v=%b want 0 v=1", rk_data, rk_data_valid);
        end
    endtask

    task automatic test_sweep();
        int cyc; logic early; logic [255:0] k;
        for (int c = 0; c < 10; c++) begin
            k = rand_key();
            accept(c, k);
            cfg = 4'd12;
            tests++;
            if (exp_valid !== 1'b0) begin
                fails++; $display("FAIL sweep_drop cfg%0d: exp_valid=%b want 0", c, exp_valid);
            end
            wait_exp(cyc, early);
            tests++;
            if (cyc !== tt[c] - mt[c] || early !== 1'b0 || exp_valid !== 1'b1 || n_rounds !== 7'(tt[c])) begin
                fails++; $display("FAIL sweep_lat cfg%0d: busy=%0d early=%b ev=%b nr=%0d want %0d 0 1 %0d",
                                  c, cyc, early, exp_valid, n_rounds, tt[c] - mt[c], tt[c]);
            end
            gen_model(c, k);
            read_block(tt[c]);
            for (int i = 0; i < tt[c]; i++) begin
                tests++;
                if (got[i] !== exp_k[i] || gotv[i] !== 1'b1) begin
                    fails++; $display("FAIL sweep_k cfg%0d i=%0d: got %h v=%b want %h v=1", c, i, got[i], gotv[i], exp_k[i]);
                end
            end
        end
    endtask

    task automatic test_cfg_err();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (k_ready !== 1'b1 || exp_valid !== 1'b0) begin
            fails++; $display("FAIL done_abort: k_ready=%b exp_valid=%b want 1 0", k_ready, exp_valid);
        end
        cfg = 4'd12; key = rand_key(); k_valid = 1'b1;
        step();
        k_valid = 1'b0;
        tests++;
        if (cfg_err !== 1'b1 || k_ready !== 1'b1 || exp_valid !== 1'b0) begin
            fails++; $display("FAIL cfg_err_pulse: cfg_err=%b k_ready=%b exp_valid=%b want 1 1 0", cfg_err, k_ready, exp_valid);
        end
        step();
        tests++;
        if (cfg_err !== 1'b0 || k_ready !== 1'b1 || exp_valid !== 1'b0) begin
            fails++; $display("FAIL cfg_err_end: cfg_err=%b k_ready=%b exp_valid=%b want 0 1 0", cfg_err, k_ready, exp_valid);
        end
        cfg = 4'd0; k_valid = 1'b1; abort = 1'b1;
        step();
        k_valid = 1'b0; abort = 1'b0;
        tests++;
        if (k_ready !== 1'b1 || cfg_err !== 1'b0) begin
            fails++; $display("FAIL abort_wins: k_ready=%b cfg_err=%b want 1 0", k_ready, cfg_err);
        end
    endtask

    task automatic test_abort();
        int cyc; logic early; logic seen; logic [255:0] k;
        accept(9, rand_key());
        for (int i = 0; i < 9; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (k_ready !== 1'b1 || exp_valid !== 1'b0) begin
            fails++; $display("FAIL exp_abort: k_ready=%b exp_valid=%b want 1 0", k_ready, exp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (exp_valid) seen = 1'b1;
            step();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL abort_no_valid: exp_valid seen=%b want 0", seen);
        end
        read_one(0);
        tests++;
        if (rk_data_valid !== 1'b0) begin
            fails++; $display("FAIL idle_read: rk_data_valid=%b want 0", rk_data_valid);
        end
        k = rand_key();
        accept(9, k);
        wait_exp(cyc, early);
        tests++;
        if (cyc !== 68 || early !== 1'b0 || exp_valid !== 1'b1) begin
            fails++; $display("FAIL abort_relat: busy=%0d early=%b ev=%b want 68 0 1", cyc, early, exp_valid);
        end
        gen_model(9, k);
        read_block(72);
        for (int i = 0; i < 72; i++) begin
            tests++;
            if (got[i] !== exp_k[i] || gotv[i] !== 1'b1) begin
                fails++; $display("FAIL abort_k i=%0d: got %h v=%b want %h v=1", i, got[i], gotv[i], exp_k[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic seen;
        accept(4, rand_key());
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (k_ready !== 1'b1 || exp_valid !== 1'b0 || cfg_err !== 1'b0 || n_rounds !== 7'd0) begin
            fails++; $display("FAIL rst_mid_ctl: k_ready=%b ev=%b cfg_err=%b nr=%0d want 1 0 0 0", k_ready, exp_valid, cfg_err, n_rounds);
        end
        tests++;
        if (rk_data !== 64'd0 || rk_data_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_rd: rk_data=%h v=%b want 0 0", rk_data, rk_data_valid);
        end
        read_one(3);
        tests++;
        if (rk_data !== 64'd0 || rk_data_valid !== 1'b0) begin
            fails++; $display("FAIL rst_idle_read: rk_data=%h v=%b want 0 0", rk_data, rk_data_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_valid || !k_ready) seen = 1'b1;
            step();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++; $display("FAIL rst_stays_idle: activity seen=%b want 0", seen);
        end
    endtask

    initial begin
        zs[0] = "11111010001001010110000111001101111101000100101011000011100110";
        zs[1] = "10001110111110010011000010110101000111011111001001100001011010";
        zs[2] = "10101111011100000011010010011000101000010001111110010110110011";
        zs[3] = "11011011101011000110010111100000010010001010011100110100001111";
        zs[4] = "11010001111001101011011000100000010111000011001010010011101111";
        test_reset();
        test_cfg7();
        test_cfg0();
        test_sweep();
        test_cfg_err();
        test_abort();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
